// File: rtl/pow_seq_pkg.sv
// Shared types and helpers for the pow_seq square-and-multiply exponentiation engine.
package pow_seq_pkg;

  localparam int unsigned POW_MAXW = 128;
  localparam int unsigned POW_MAXE = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } pow_state_e;

  typedef struct packed {
    logic                hit;
    logic [POW_MAXW-1:0] result;
    logic                undef;
  } pow_special_t;

  function automatic int unsigned exp_bitlen(input logic [POW_MAXE-1:0] e);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POW_MAXE; i++) begin
      if (e[i]) n = i + 1;
    end
    return n;
  endfunction

  // Caller sign-extends base, so -1 appears as all-ones regardless of WIDTH.
  function automatic pow_special_t pow_special(input logic [POW_MAXW-1:0] base,
                                               input logic exp_neg,
                                               input logic exp_odd);
    pow_special_t r;
    r = '0;
    r.hit = exp_neg;
    if (exp_neg) begin
      if (base == '0) r.undef = 1'b1;
      else if (base == POW_MAXW'(1)) r.result = POW_MAXW'(1);
      else if (base == '1) r.result = exp_odd ? '1 : POW_MAXW'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pow_seq_mul.sv
// Combinational WIDTH x WIDTH multiplier keeping only the low WIDTH bits.
module pow_seq_mul #(
  parameter int unsigned WIDTH = 67
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/pow_seq.sv
// Multi-cycle base**exp mod 2^WIDTH engine with valid/ready on both sides.
// Optional macro POW_SEQ_SHIFT_FAST_EN resolves base==2 (non-negative exp) in IDLE.
module pow_seq
  import pow_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 67,
  parameter int unsigned EXP_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_undef,
  output logic             busy
);

  pow_state_e       state, state_d;
  logic [WIDTH-1:0] acc, acc_d, sq, sq_d, res_q, res_d;
  logic [WIDTH-1:0] acc_n, prod_as, prod_ss;
  logic [EXP_W-1:0] e, e_d;
  logic             undef_q, undef_d;
  logic             exp_neg;
  pow_special_t     spec_r;
  logic             unused_spec_bits;

  assign exp_neg          = in_signed & in_exp[EXP_W-1];
  assign spec_r           = pow_special(POW_MAXW'($signed(in_base)), exp_neg, in_exp[0]);
  assign unused_spec_bits = ^spec_r.result[POW_MAXW-1:WIDTH];

  pow_seq_mul #(.WIDTH(WIDTH)) u_mul_acc (.a(acc), .b(sq), .p(prod_as));
  pow_seq_mul #(.WIDTH(WIDTH)) u_mul_sq  (.a(sq),  .b(sq), .p(prod_ss));

`ifdef POW_SEQ_SHIFT_FAST_EN
  logic             fast_hit;
  logic [WIDTH-1:0] shift_r;
  assign fast_hit = (in_base == WIDTH'(2)) && !exp_neg;
  assign shift_r  = (POW_MAXE'(in_exp) >= POW_MAXE'(WIDTH)) ? '0 : (WIDTH'(1) << in_exp);
`endif

  assign acc_n = e[0] ? prod_as : acc;

  always_comb begin
    state_d = state;
    acc_d   = acc;
    sq_d    = sq;
    e_d     = e;
    res_d   = res_q;
    undef_d = undef_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          undef_d = 1'b0;
          if (spec_r.hit) begin
            res_d   = spec_r.result[WIDTH-1:0];
            undef_d = spec_r.undef;
            state_d = DONE;
          end
`ifdef POW_SEQ_SHIFT_FAST_EN
          else if (fast_hit) begin
            res_d   = shift_r;
            state_d = DONE;
          end
`endif
          else if (in_exp == '0) begin
            res_d   = WIDTH'(1);
            state_d = DONE;
          end else begin
            acc_d   = WIDTH'(1);
            sq_d    = in_base;
            e_d     = in_exp;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = acc_n;
        sq_d  = prod_ss;
        e_d   = e >> 1;
        if ((e >> 1) == '0) begin
          res_d   = acc_n;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      sq      <= '0;
      e       <= '0;
      res_q   <= '0;
      undef_q <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      sq      <= sq_d;
      e       <= e_d;
      res_q   <= res_d;
      undef_q <= undef_d;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_result = res_q;
  assign out_undef  = undef_q;

endmodule
